ball_engine: RTL and testbench

- Next-generation Pong ball: parametrised size, speed, playfield bounds, paddle collision, scoring and a serve state machine.
- Runs on the pixel clock. Samples the VGA `endofframe` strobe and moves the ball once per frame.
- Drives `ball_on` and RGB for the VGA output mux. Emits score pulses to the score-keeping logic.

---
 rtl/ball_engine.sv | 177 +++++++++++++++++
 tb/tb_ball_engine.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Pong ball: serve FSM, once-per-frame motion, wall clamps, paddle bounces and miss scoring.
// Geometry is evaluated in 11 bits so that edge sums never wrap.
module ball_engine #(
    parameter int         BALL_SIZE      = 10,
    parameter int         SPEED_X        = 2,
    parameter int         SPEED_Y        = 1,
    parameter int         H_ACTIVE       = 640,
    parameter int         V_ACTIVE       = 480,
    parameter int         TOP_LIMIT      = 3,
    parameter int         BOTTOM_LIMIT   = 477,
    parameter int         LEFT_PADDLE_X  = 30,
    parameter int         RIGHT_PADDLE_X = 600,
    parameter int         PADDLE_H       = 48,
    parameter int         SERVE_FRAMES   = 60,
    parameter logic [7:0] BALL_RGB       = 8'b000_111_00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       endofframe,
    input  logic       serve,
    input  logic [9:0] lpad_y,
    input  logic [9:0] rpad_y,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       ball_on,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       score_left,
    output logic       score_right
);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_PLAY   = 2'd2;
    localparam logic [1:0] S_SCORED = 2'd3;

    localparam int CW = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [9:0]  X_CENTRE = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_CENTRE = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] BS_M1    = 11'(BALL_SIZE - 1);
    localparam logic [10:0] SX       = 11'(SPEED_X);
    localparam logic [10:0] SY       = 11'(SPEED_Y);
    localparam logic [10:0] TOP_L    = 11'(TOP_LIMIT);
    localparam logic [10:0] BOT_L    = 11'(BOTTOM_LIMIT);
    localparam logic [10:0] LPX      = 11'(LEFT_PADDLE_X);
    localparam logic [10:0] RPX      = 11'(RIGHT_PADDLE_X);
    localparam logic [10:0] PH_M1    = 11'(PADDLE_H - 1);
    localparam logic [10:0] H_M1     = 11'(H_ACTIVE - 1);

    logic [1:0]    state_q, state_d;
    logic [9:0]    ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic          dir_x_q, dir_x_d;   // 1 = right
    logic          dir_y_q, dir_y_d;   // 1 = down
    logic [CW-1:0] cnt_q, cnt_d;
    logic          eof_q;
    logic          score_l_q, score_l_d, score_r_q, score_r_d;

    logic          tick;
    logic [10:0]   left, right, top, bottom, lpad, rpad;
    logic          l_overlap, r_overlap, l_miss, r_miss, l_hit, r_hit;

    assign tick   = endofframe & ~eof_q;
    assign left   = {1'b0, ball_x_q};
    assign right  = {1'b0, ball_x_q} + BS_M1;
    assign top    = {1'b0, ball_y_q};
    assign bottom = {1'b0, ball_y_q} + BS_M1;
    assign lpad   = {1'b0, lpad_y};
    assign rpad   = {1'b0, rpad_y};

    assign l_overlap = (bottom >= lpad) && (top <= lpad + PH_M1);
    assign r_overlap = (bottom >= rpad) && (top <= rpad + PH_M1);
    assign l_miss    = ~dir_x_q && (left <= SX);
    assign r_miss    = dir_x_q && (right + SX >= H_M1);
    assign l_hit     = ~dir_x_q && (left >= LPX + 11'd1) && (left <= LPX + SX) && l_overlap;
    assign r_hit     = dir_x_q && (right >= RPX - SX) && (right <= RPX - 11'd1) && r_overlap;

    always_comb begin
        state_d   = state_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        cnt_d     = cnt_q;
        score_l_d = 1'b0;
        score_r_d = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (serve) begin
                    state_d = S_DELAY;
                    cnt_d   = '0;
                end
            end
            S_DELAY: begin
                if (tick) begin
                    if (cnt_q == CW'(SERVE_FRAMES - 1)) state_d = S_PLAY;
                    else                                cnt_d   = cnt_q + 1'b1;
                end
            end
            S_PLAY: begin
                // A miss freezes the ball where it is; direction already points at the conceder.
                if (tick && l_miss) begin
                    state_d   = S_SCORED;
                    score_r_d = 1'b1;
                end else if (tick && r_miss) begin
                    state_d   = S_SCORED;
                    score_l_d = 1'b1;
                end else if (tick) begin
                    if (~dir_y_q && (top <= TOP_L + SY)) begin
                        ball_y_d = TOP_L[9:0];
                        dir_y_d  = 1'b1;
                    end else if (dir_y_q && (bottom + SY >= BOT_L)) begin
                        ball_y_d = 10'(BOT_L - BS_M1);
                        dir_y_d  = 1'b0;
                    end else begin
                        ball_y_d = dir_y_q ? ball_y_q + SY[9:0] : ball_y_q - SY[9:0];
                    end
                    if (l_hit) begin
                        ball_x_d = 10'(LPX + 11'd1);
                        dir_x_d  = 1'b1;
                    end else if (r_hit) begin
                        ball_x_d = 10'(RPX - BS_M1 - 11'd1);
                        dir_x_d  = 1'b0;
                    end else begin
                        ball_x_d = dir_x_q ? ball_x_q + SX[9:0] : ball_x_q - SX[9:0];
                    end
                end
            end
            default: begin
                if (tick) begin
                    state_d  = S_WAIT;
                    ball_x_d = X_CENTRE;
                    ball_y_d = Y_CENTRE;
                    dir_y_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_WAIT;
            ball_x_q  <= X_CENTRE;
            ball_y_q  <= Y_CENTRE;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            cnt_q     <= '0;
            eof_q     <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            cnt_q     <= cnt_d;
            eof_q     <= endofframe;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
        end
    end

    assign ball_on     = ({1'b0, x} >= left) && ({1'b0, x} <= right) &&
                         ({1'b0, y} >= top)  && ({1'b0, y} <= bottom);
    assign red         = ball_on ? BALL_RGB[7:5] : 3'd0;
    assign green       = ball_on ? BALL_RGB[4:2] : 3'd0;
    assign blue        = ball_on ? BALL_RGB[1:0] : 2'd0;
    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign score_left  = score_l_q;
    assign score_right = score_r_q;

endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine: a frame-level model pushes expected ball state per tick,
// popped and compared after the DUT updates; key geometry points are also checked as constants.
module tb_ball_engine;

    localparam int BS = 10, SX = 2, SY = 1, H = 640, TOP = 3, BOT = 477;
    localparam int LPX = 30, RPX = 600, PH = 48, SF = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] x = '0, y = '0, lpad_y = '0, rpad_y = '0;
    logic       endofframe = 1'b0, serve = 1'b0;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       ball_on, score_left, score_right;
    logic [9:0] ball_x, ball_y;

    ball_engine #(.SERVE_FRAMES(SF)) dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .endofframe(endofframe),
        .serve(serve), .lpad_y(lpad_y), .rpad_y(rpad_y), .red(red), .green(green),
        .blue(blue), .ball_on(ball_on), .ball_x(ball_x), .ball_y(ball_y),
        .score_left(score_left), .score_right(score_right)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit sl;
        bit sr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0;

    // Reference ball state; st: 0 WAIT, 1 DELAY, 2 PLAY, 3 SCORED
    int m_x, m_y, m_st, m_cnt;
    bit m_dx, m_dy;

    task automatic model_reset();
        m_x = 315; m_y = 235; m_st = 0; m_cnt = 0; m_dx = 1; m_dy = 1;
    endtask

    task automatic model_tick();
        exp_t e;
        int l, r, t, b, lp, rp;
        bit ovl, ovr, sl, sr;
        sl = 0; sr = 0;
        l = m_x; r = m_x + BS - 1; t = m_y; b = m_y + BS - 1;
        lp = int'(lpad_y); rp = int'(rpad_y);
        ovl = (b >= lp) && (t <= lp + PH - 1);
        ovr = (b >= rp) && (t <= rp + PH - 1);
        case (m_st)
            1: if (m_cnt == SF - 1) m_st = 2; else m_cnt++;
            2: begin
                if (!m_dx && l <= SX) begin sr = 1; m_st = 3; end
                else if (m_dx && r + SX >= H - 1) begin sl = 1; m_st = 3; end
                else begin
                    if (!m_dy && t <= TOP + SY) begin m_y = TOP; m_dy = 1; end
                    else if (m_dy && b + SY >= BOT) begin m_y = BOT - BS + 1; m_dy = 0; end
                    else m_y = m_dy ? m_y + SY : m_y - SY;
                    if (!m_dx && l >= LPX + 1 && l <= LPX + SX && ovl) begin m_x = LPX + 1; m_dx = 1; end
                    else if (m_dx && r >= RPX - SX && r <= RPX - 1 && ovr) begin m_x = RPX - BS; m_dx = 0; end
                    else m_x = m_dx ? m_x + SX : m_x - SX;
                end
            end
            3: begin m_x = 315; m_y = 235; m_dy = 1; m_st = 0; end
            default: ;
        endcase
        e.x = m_x; e.y = m_y; e.sl = sl; e.sr = sr;
        sb.push_back(e);
    endtask

    // One endofframe pulse; compares the popped expectation, then that score pulses last one clk.
    task automatic frame();
        exp_t e;
        model_tick();
        @(negedge clk) endofframe = 1'b1;
        @(posedge clk) #1;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL frame_queue: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({ball_x, ball_y, score_left, score_right} !== {10'(e.x), 10'(e.y), e.sl, e.sr}) begin
                fails++;
                $display("FAIL frame: got x=%0d y=%0d sl=%b sr=%b, want x=%0d y=%0d sl=%b sr=%b",
                         ball_x, ball_y, score_left, score_right, e.x, e.y, e.sl, e.sr);
            end
            @(negedge clk) endofframe = 1'b0;
            @(posedge clk) #1;
            if (e.sl || e.sr) begin
                tests++;
                if ({score_left, score_right} !== 2'b00) begin
                    fails++;
                    $display("FAIL pulse_width: got sl=%b sr=%b, want 00", score_left, score_right);
                end
            end
        end
    endtask

    task automatic do_serve();
        @(negedge clk) serve = 1'b1;
        @(posedge clk);
        if (m_st == 0) begin m_st = 1; m_cnt = 0; end
        @(negedge clk) serve = 1'b0;
    endtask

    task automatic track_paddles();
        lpad_y = (m_y >= 5) ? 10'(m_y - 5) : 10'd0;
        rpad_y = lpad_y;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({ball_x, ball_y, score_left, score_right} !== {10'd315, 10'd235, 2'b00}) begin
            fails++;
            $display("FAIL reset_state: got x=%0d y=%0d sl=%b sr=%b, want 315 235 0 0",
                     ball_x, ball_y, score_left, score_right);
        end
        x = 10'd315; y = 10'd235; #1;
        tests++;
        if ({ball_on, red, green, blue} !== {1'b1, 3'd0, 3'd7, 2'd0}) begin
            fails++;
            $display("FAIL pixel_in: got on=%b rgb=%0d/%0d/%0d, want 1 0/7/0", ball_on, red, green, blue);
        end
        x = 10'd325; #1;
        tests++;
        if ({ball_on, red, green, blue} !== 9'd0) begin
            fails++;
            $display("FAIL pixel_out: got on=%b rgb=%0d/%0d/%0d, want 0 0/0/0", ball_on, red, green, blue);
        end
        x = 10'd324; y = 10'd244; #1;
        tests++;
        if (ball_on !== 1'b1) begin
            fails++;
            $display("FAIL pixel_corner: got on=%b, want 1", ball_on);
        end
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_serve();
        frame();  // WAIT: stationary without a serve
        do_serve();
        for (int i = 0; i < SF; i++) begin
            frame();
            if (i == 1) begin
                @(negedge clk) serve = 1'b1;
                @(negedge clk) serve = 1'b0;
            end
        end
        tests++;
        if ({ball_x, ball_y} !== {10'd315, 10'd235}) begin
            fails++;
            $display("FAIL serve_delay: got %0d,%0d want 315,235", ball_x, ball_y);
        end
        frame();
        tests++;
        if ({ball_x, ball_y} !== {10'd317, 10'd236}) begin
            fails++;
            $display("FAIL serve_launch: got %0d,%0d want 317,236", ball_x, ball_y);
        end
    endtask

    task automatic test_right_paddle();
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            track_paddles();
            frame();
            found = (m_x == 590 && !m_dx);
        end
        tests++;
        if (!found || ball_x !== 10'd590) begin
            fails++;
            $display("FAIL right_bounce: got x=%0d found=%0d want 590", ball_x, found);
        end
        track_paddles();
        frame();
        tests++;
        if (ball_x !== 10'd588) begin
            fails++;
            $display("FAIL right_after: got x=%0d want 588", ball_x);
        end
    endtask

    task automatic test_walls();
        bit found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            track_paddles();
            frame();
            found = (m_y == 468 && !m_dy);
        end
        tests++;
        if (!found || ball_y !== 10'd468) begin
            fails++;
            $display("FAIL bottom_clamp: got y=%0d found=%0d want 468", ball_y, found);
        end
        track_paddles();
        frame();
        tests++;
        if (ball_y !== 10'd467) begin
            fails++;
            $display("FAIL bottom_after: got y=%0d want 467", ball_y);
        end
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            track_paddles();
            frame();
            found = (m_y == 3 && m_dy);
        end
        tests++;
        if (!found || ball_y !== 10'd3) begin
            fails++;
            $display("FAIL top_clamp: got y=%0d found=%0d want 3", ball_y, found);
        end
        track_paddles();
        frame();
        tests++;
        if (ball_y !== 10'd4) begin
            fails++;
            $display("FAIL top_after: got y=%0d want 4", ball_y);
        end
    endtask

    task automatic test_left_miss();
        bit found = 0;
        for (int i = 0; i < 800 && !found; i++) begin
            // Left paddle parked where it cannot overlap the ball.
            rpad_y = (m_y >= 5) ? 10'(m_y - 5) : 10'd0;
            lpad_y = (m_y < 200) ? 10'd400 : 10'd0;
            frame();
            found = (m_st == 3);
        end
        tests++;
        if (!found || ball_x > 10'd2 || score_left !== 1'b0) begin
            fails++;
            $display("FAIL left_miss: got x=%0d sl=%b found=%0d want x<=2 sl=0", ball_x, score_left, found);
        end
        frame();
        tests++;
        if ({ball_x, ball_y} !== {10'd315, 10'd235}) begin
            fails++;
            $display("FAIL recentre: got %0d,%0d want 315,235", ball_x, ball_y);
        end
        frame();  // still WAIT
        do_serve();
        for (int i = 0; i <= SF; i++) frame();
        tests++;
        if ({ball_x, ball_y} !== {10'd313, 10'd236}) begin
            fails++;
            $display("FAIL reserve_left: got %0d,%0d want 313,236", ball_x, ball_y);
        end
    endtask

    task automatic test_hold_and_reset();
        exp_t e;
        track_paddles();
        model_tick();
        @(negedge clk) endofframe = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        e = sb.pop_front();
        tests++;
        if ({ball_x, ball_y} !== {10'(e.x), 10'(e.y)}) begin
            fails++;
            $display("FAIL hold_one_move: got %0d,%0d want %0d,%0d", ball_x, ball_y, e.x, e.y);
        end
        @(negedge clk) endofframe = 1'b0;
        @(posedge clk) #1;
        track_paddles();
        frame();
        frame();
        @(posedge clk) #3 reset_n = 1'b0;
        #1;
        tests++;
        if ({ball_x, ball_y, score_left, score_right} !== {10'd315, 10'd235, 2'b00}) begin
            fails++;
            $display("FAIL reset_mid: got x=%0d y=%0d sl=%b sr=%b, want 315 235 0 0",
                     ball_x, ball_y, score_left, score_right);
        end
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        frame();  // WAIT after reset: no motion
        do_serve();
        for (int i = 0; i <= SF; i++) frame();
        tests++;
        if ({ball_x, ball_y} !== {10'd317, 10'd236}) begin
            fails++;
            $display("FAIL reset_reserve: got %0d,%0d want 317,236", ball_x, ball_y);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_right_paddle();
        test_walls();
        test_left_miss();
        test_hold_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
